// File: rtl/aes128_type_pkg.sv
// Shared AES-128 types: cipher mode, GF(2^8) constants and multiplier FSM states.
// Used by the mix-column datapath and aes128_gf_mult.
package aes128_type_pkg;

    typedef enum logic {
        ENCRYPT = 1'b0,
        DECRYPT = 1'b1
    } mode_t;

    // Low byte of x^8+x^4+x^3+x+1; the x^8 term is implied by the carry-out.
    localparam logic [7:0] AES_POLY_LOW = 8'h1B;

    localparam logic [2:0] GMUL_LAST_STEP = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gmul_state_t;

endpackage

// File: rtl/aes128_xtime.sv
// Multiply a GF(2^8) element by x modulo the AES polynomial 0x11B.
// Purely combinational.
module aes128_xtime
    import aes128_type_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] doubled
);

    always_comb begin
        doubled = {value[6:0], 1'b0} ^ (value[7] ? AES_POLY_LOW : 8'h00);
    end

endmodule

// File: rtl/aes128_gf_mult.sv
// Bit-serial GF(2^8) multiplier, one multiplier bit per clock.
// Optional macro AES128_GMUL_EARLY_EXIT_EN stops once no multiplier bits remain.
module aes128_gf_mult
    import aes128_type_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       start_i,
    output logic [7:0] result_o,
    output logic       valid_o
);

    gmul_state_t state;
    gmul_state_t state_next;

    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [7:0] p_r;
    logic [2:0] cnt;

    logic [7:0] a_next;
    logic [7:0] b_next;
    logic [7:0] p_next;
    logic [2:0] cnt_next;

    logic [7:0] b_x;
    logic       calc_last;

    aes128_xtime u_xtime (
        .value   (b_r),
        .doubled (b_x)
    );

`ifdef AES128_GMUL_EARLY_EXIT_EN
    // Post-shift multiplier is zero: remaining steps would add nothing.
    assign calc_last = (cnt == GMUL_LAST_STEP) || (a_r[7:1] == 7'd0);
`else
    assign calc_last = (cnt == GMUL_LAST_STEP);
`endif

    always_comb begin
        state_next = state;
        a_next     = a_r;
        b_next     = b_r;
        p_next     = p_r;
        cnt_next   = cnt;
        unique case (1'b1)
            (state == IDLE): begin
                if (start_i) begin
                    a_next     = a_i;
                    b_next     = b_i;
                    p_next     = 8'h00;
                    cnt_next   = 3'd0;
                    state_next = CALC;
                end
            end
            (state == CALC): begin
                if (a_r[0]) begin
                    p_next = p_r ^ b_r;
                end
                b_next   = b_x;
                a_next   = {1'b0, a_r[7:1]};
                cnt_next = cnt + 3'd1;
                if (calc_last) begin
                    state_next = DONE;
                end
            end
            (state == DONE): begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            a_r   <= 8'h00;
            b_r   <= 8'h00;
            p_r   <= 8'h00;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            a_r   <= a_next;
            b_r   <= b_next;
            p_r   <= p_next;
            cnt   <= cnt_next;
        end
    end

    assign result_o = p_r;
    assign valid_o  = (state == DONE);

endmodule

// File: tb/tb_aes128_gf_mult.sv
// Self-checking bench for aes128_gf_mult against a polynomial-arithmetic model.
// Honours AES128_GMUL_EARLY_EXIT_EN for expected latencies.
module tb_aes128_gf_mult;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       start;
    logic [7:0] result;
    logic       valid;

    int total;
    int bad;

    aes128_gf_mult dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .a_i      (a),
        .b_i      (b),
        .start_i  (start),
        .result_o (result),
        .valid_o  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Carry-less product, then long division by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] acc;
        logic [15:0] poly;
        acc = 16'h0;
        for (int i = 0; i < 8; i++)
            if (x[i]) acc = acc ^ (16'(y) << i);
        for (int i = 15; i >= 8; i--) begin
            poly = 16'h011B << (i - 8);
            if (acc[i]) acc = acc ^ poly;
        end
        return acc[7:0];
    endfunction

    function automatic int calc_len(input logic [7:0] x);
`ifdef AES128_GMUL_EARLY_EXIT_EN
        int n;
        n = 1;
        for (int i = 0; i < 8; i++)
            if (x[i]) n = i + 1;
        return n;
`else
        return 8;
`endif
    endfunction

    // One operation with a one-cycle start pulse; lat = cycle of valid.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb,
                          output logic [7:0] res, output int lat);
        lat = -1;
        res = 8'h00;
        @(negedge clk);
        a = xa;
        b = xb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (valid) begin
                lat = n;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic seen;
        @(negedge clk);
        a = 8'h83;
        b = 8'h57;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", valid);
        end
        total++;
        if (result !== 8'h00) begin
            bad++;
            $display("FAIL reset_result: got %h want 00", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (valid !== 1'b0 || result !== 8'h00) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: activity seen=%b want 0", seen);
        end
    endtask

    task automatic test_vectors;
        logic [7:0] va [6] = '{8'h83, 8'h13, 8'h02, 8'h03, 8'h01, 8'h00};
        logic [7:0] vb [6] = '{8'h57, 8'h57, 8'hD4, 8'hBF, 8'h5A, 8'hFF};
        logic [7:0] vr [6] = '{8'hC1, 8'hFE, 8'hB3, 8'hDA, 8'h5A, 8'h00};
        logic [7:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], res, lat);
            total++;
            if (res !== vr[i] || lat != calc_len(va[i]) + 1) begin
                bad++;
                $display("FAIL fips_%0d: got %h@%0d want %h@%0d",
                         i, res, lat, vr[i], calc_len(va[i]) + 1);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] xa;
        logic [7:0] xb;
        logic [7:0] res;
        int lat;
        for (int i = 0; i < 24; i++) begin
            xa = 8'($urandom);
            xb = 8'($urandom);
            run_op(xa, xb, res, lat);
            total++;
            if (res !== gmul(xa, xb) || lat != calc_len(xa) + 1) begin
                bad++;
                $display("FAIL rand a=%h b=%h: got %h@%0d want %h@%0d",
                         xa, xb, res, lat, gmul(xa, xb), calc_len(xa) + 1);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] oa [3];
        logic [7:0] ob [3];
        int exp_cyc [3];
        int cyc;
        int k;
        int s;
        logic prev_valid;
        logic upd;
        logic late;
        oa[0] = 8'h02; ob[0] = 8'hD4;
        for (int i = 1; i < 3; i++) begin
            oa[i] = 8'($urandom);
            ob[i] = 8'($urandom);
        end
        s = 0;
        for (int i = 0; i < 3; i++) begin
            exp_cyc[i] = s + calc_len(oa[i]) + 1;
            s = exp_cyc[i] + 1;
        end
        @(negedge clk);
        a = oa[0];
        b = ob[0];
        start = 1'b1;
        cyc = 0;
        k = 0;
        prev_valid = 1'b0;
        upd = 1'b0;
        while (k < 3 && cyc < 60) begin
            @(posedge clk);
            cyc++;
            #1;
            if (upd) begin
                a = oa[k];
                b = ob[k];
                upd = 1'b0;
            end
            @(negedge clk);
            if (valid) begin
                total++;
                if (cyc != exp_cyc[k] || result !== gmul(oa[k], ob[k]) || prev_valid) begin
                    bad++;
                    $display("FAIL b2b_%0d: got %h@%0d prev=%b want %h@%0d",
                             k, result, cyc, prev_valid, gmul(oa[k], ob[k]), exp_cyc[k]);
                end
                k++;
                upd = (k < 3);
            end
            prev_valid = valid;
        end
        total++;
        if (k != 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d results want 3", k);
        end
        @(posedge clk);
        #1 start = 1'b0;
        late = 1'b0;
        @(negedge clk);
        if (valid) late = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (valid) late = 1'b1;
        end
        total++;
        if (late !== 1'b0) begin
            bad++;
            $display("FAIL b2b_tail: extra valid=%b want 0", late);
        end
    endtask

    task automatic test_column;
        logic [7:0] ca [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [7:0] cb [4] = '{8'hDB, 8'h13, 8'h53, 8'h45};
        logic [7:0] ia [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        logic [7:0] ib [4] = '{8'h8E, 8'h4D, 8'hA1, 8'hBC};
        logic [7:0] acc;
        logic [7:0] res;
        int lat;
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            run_op(ca[i], cb[i], res, lat);
            acc = acc ^ res;
        end
        total++;
        if (acc !== 8'h8E) begin
            bad++;
            $display("FAIL column_fwd: got %h want 8e", acc);
        end
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            run_op(ia[i], ib[i], res, lat);
            acc = acc ^ res;
        end
        total++;
        if (acc !== 8'hDB) begin
            bad++;
            $display("FAIL column_inv: got %h want db", acc);
        end
    endtask

    task automatic test_start_drop;
        logic [7:0] res;
        int lat;
        logic extra;
        logic held;
        run_op(8'h02, 8'h80, res, lat);
        total++;
        if (res !== 8'h1B || lat != calc_len(8'h02) + 1) begin
            bad++;
            $display("FAIL start_drop: got %h@%0d want 1b@%0d", res, lat, calc_len(8'h02) + 1);
        end
        a = 8'hFF;
        b = 8'hFF;
        extra = 1'b0;
        held = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (valid) extra = 1'b1;
            if (result !== 8'h1B) held = 1'b0;
        end
        total++;
        if (extra !== 1'b0 || held !== 1'b1) begin
            bad++;
            $display("FAIL start_drop_tail: extra=%b held=%b want 0 1", extra, held);
        end
    endtask

    task automatic test_early_exit;
        logic [7:0] res;
        int lat;
        run_op(8'h0E, 8'h8E, res, lat);
        total++;
        if (res !== gmul(8'h0E, 8'h8E) || lat != calc_len(8'h0E) + 1) begin
            bad++;
            $display("FAIL early_0e: got %h@%0d want %h@%0d",
                     res, lat, gmul(8'h0E, 8'h8E), calc_len(8'h0E) + 1);
        end
        run_op(8'h80, 8'h03, res, lat);
        total++;
        if (res !== gmul(8'h80, 8'h03) || lat != 9) begin
            bad++;
            $display("FAIL early_80: got %h@%0d want %h@9", res, lat, gmul(8'h80, 8'h03));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        #12;
        total++;
        if (valid !== 1'b0 || result !== 8'h00) begin
            bad++;
            $display("FAIL por_state: got v=%b r=%h want 0 00", valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_reset;
        test_vectors;
        test_random;
        test_back_to_back;
        test_column;
        test_start_drop;
        test_early_exit;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
